keypad_conditioner: RTL and testbench
=====================================

Name: keypad_conditioner

Overview:
- Front-end input stage directly upstream of the doorlock password state machine.
- Synchronises and debounces the raw start, end and ten digit push-buttons, then encodes digit presses to a 4-bit value.
- Sequences an entry session and drives single-cycle ps_start / ps_end pulses plus ps_num with a valid strobe to the lock core.

Parameters:
- DEBOUNCE_TICKS, 8, number of consecutive tick_en samples an input must stay changed before it is accepted.
- MAX_DIGITS, 4, maximum digits accepted per session; further digits are dropped.
- TIMEOUT_TICKS, 1000, inactivity limit in tick_en samples (used only with KEY_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- tick_en  in  1  sample enable from the clock divider; debounce and timeout counters advance only when it is 1.
- btn_start  in  1  raw start button, active-high, asynchronous.
- btn_end  in  1  raw end button, active-high, asynchronous.
- key_in  in  10  raw digit keys; bit k is digit k; active-high, asynchronous.
- ps_start  out  1  one-cycle session start pulse.
- ps_end  out  1  one-cycle session end pulse.
- ps_num  out  4  last accepted digit, 0..9; holds its value between strobes.
- num_valid  out  1  one-cycle strobe; ps_num is new this cycle.
- digit_cnt  out  3  digits accepted in the current session.
- entry_active  out  1  high while in the ENTRY state.
- timeout  out  1  one-cycle abort pulse; tied 0 when KEY_TIMEOUT_EN is undefined.

Behaviour:
- Reset and clocking: one clock, clk. rst is synchronous and active-high. On reset:
  - all outputs = 0, state = IDLE;
  - synchronisers, debounced levels and counters cleared; rst overrides all other inputs.
- Synchronisation: every raw input passes through a 2-flop synchroniser, giving 2 cycles of latency.
- Debounce, per input:
  - On each tick_en with synced != stable, the counter increments. When synced == stable, the counter clears.
  - When the counter reaches DEBOUNCE_TICKS-1 on a tick and the input still differs, stable flips and the counter clears.
  - Cycles without tick_en hold the counter.
- Edge detect: a stable rising edge gives a 1-cycle internal event. Falling edges are ignored.
- Digit encode: if several digit events fire in the same cycle, the lowest index wins and the others are discarded.
- State machine, states IDLE, ENTRY, DONE:
  - IDLE:
    - start event -> ENTRY; ps_start=1 for that cycle; digit_cnt=0.
    - Digit and end events are ignored.
  - ENTRY:
    - Digit event with digit_cnt < MAX_DIGITS -> ps_num=digit, num_valid=1, digit_cnt+1.
    - Digit event with digit_cnt == MAX_DIGITS -> dropped; no strobe; count saturates.
    - Start event -> restart: ps_start=1, digit_cnt=0, stay in ENTRY; a digit in the same cycle is dropped.
    - End event -> DONE; ps_end=1 the same cycle.
    - Digit and end in the same cycle -> the digit is accepted and ps_end=1 in that same cycle.
  - DONE: unconditionally -> IDLE next cycle; digit_cnt holds until the next start.
  - Start and end together in IDLE: start wins and end is ignored.
- Registered outputs: all outputs are registered. A pulse appears on the cycle after the debounced edge.

Optional Feature:
- Macro: KEY_TIMEOUT_EN.
- Defined:
  - An inactivity counter runs in ENTRY, counting tick_en cycles.
  - It clears on entry to ENTRY and on every accepted digit or restart.
  - On reaching TIMEOUT_TICKS: timeout=1 for one cycle, state -> IDLE, digit_cnt=0, no ps_end.
- Undefined: no counter; timeout held at 0; ENTRY waits indefinitely.

Test Plan:
- Reset, then hold btn_start high for DEBOUNCE_TICKS+1 ticks -> exactly one ps_start pulse; entry_active=1; digit_cnt=0.
- In ENTRY, press key_in[3], then key_in[7], each held past debounce, with bounce glitches shorter than DEBOUNCE_TICKS ticks -> two num_valid strobes with ps_num=3 then 7; digit_cnt=2; glitches produce nothing.
- Six digits 1..6, then end -> strobes only for 1,2,3,4; digit_cnt=4; ps_end pulse; DONE, then IDLE one cycle later.
- key_in[5] and key_in[2] rise in the same tick -> single strobe with ps_num=2. Digit and end in the same cycle -> num_valid and ps_end in the same cycle.
- Assert rst for one cycle mid-entry, with digit_cnt=3 -> next cycle all outputs 0, state IDLE; a following digit press produces no strobe.
- With KEY_TIMEOUT_EN defined and TIMEOUT_TICKS=20: start, then 20 idle ticks -> timeout pulse, entry_active=0, no ps_end. Without the macro: timeout stays 0.

Source files
------------

// File: rtl/keypad_conditioner.sv
// Keypad front end: 2-flop sync, per-input debounce, rising-edge detect,
// digit encode and entry-session sequencing toward the lock core.
// Ports: clk, rst (sync, active-high), tick_en, btn_start, btn_end,
//   key_in[9:0] in; ps_start, ps_end, ps_num[3:0], num_valid,
//   digit_cnt[2:0], entry_active, timeout out (all registered).
// Optional: define KEY_TIMEOUT_EN for the ENTRY inactivity abort.
module keypad_conditioner #(
  parameter int DEBOUNCE_TICKS = 8,
  parameter int MAX_DIGITS     = 4,
  parameter int TIMEOUT_TICKS  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_en,
  input  logic       btn_start,
  input  logic       btn_end,
  input  logic [9:0] key_in,
  output logic       ps_start,
  output logic       ps_end,
  output logic [3:0] ps_num,
  output logic       num_valid,
  output logic [2:0] digit_cnt,
  output logic       entry_active,
  output logic       timeout
);

  localparam int NIN = 12;
  localparam int CW  = $clog2(DEBOUNCE_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;

  // bit 0 start, bit 1 end, bits 2..11 digits 0..9
  logic [NIN-1:0] raw;
  logic [NIN-1:0] sync1;
  logic [NIN-1:0] sync2;
  logic [NIN-1:0] stab;
  logic [NIN-1:0] stab_q;
  logic [NIN-1:0] rise;
  logic [CW-1:0]  dcnt [NIN];

  assign raw  = {key_in, btn_end, btn_start};
  assign rise = stab & ~stab_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      stab   <= '0;
      stab_q <= '0;
      for (int i = 0; i < NIN; i++) dcnt[i] <= '0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      stab_q <= stab;
      for (int i = 0; i < NIN; i++) begin
        if (sync2[i] == stab[i]) begin
          dcnt[i] <= '0;
        end else if (tick_en) begin
          if (dcnt[i] == CW'(DEBOUNCE_TICKS - 1)) begin
            stab[i] <= sync2[i];
            dcnt[i] <= '0;
          end else begin
            dcnt[i] <= dcnt[i] + 1'b1;
          end
        end
      end
    end
  end

  logic       start_ev;
  logic       end_ev;
  logic       dig_hit;
  logic [3:0] dig;
  logic       dig_ok;

  assign start_ev = rise[0];
  assign end_ev   = rise[1];

  // Scan downward so the lowest simultaneous digit is the one kept.
  always_comb begin
    dig_hit = 1'b0;
    dig     = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (rise[2+i]) begin
        dig_hit = 1'b1;
        dig     = 4'(i);
      end
    end
  end

  assign dig_ok = dig_hit && (digit_cnt < 3'(MAX_DIGITS));

`ifdef KEY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] idle_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ps_start     <= 1'b0;
      ps_end       <= 1'b0;
      ps_num       <= 4'd0;
      num_valid    <= 1'b0;
      digit_cnt    <= 3'd0;
      entry_active <= 1'b0;
      timeout      <= 1'b0;
`ifdef KEY_TIMEOUT_EN
      idle_cnt     <= '0;
`endif
    end else begin
      ps_start  <= 1'b0;
      ps_end    <= 1'b0;
      num_valid <= 1'b0;
      timeout   <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ev) begin
            state        <= ENTRY;
            entry_active <= 1'b1;
            ps_start     <= 1'b1;
            digit_cnt    <= 3'd0;
`ifdef KEY_TIMEOUT_EN
            idle_cnt     <= '0;
`endif
          end
        end
        ENTRY: begin
          if (start_ev) begin
            ps_start  <= 1'b1;
            digit_cnt <= 3'd0;
`ifdef KEY_TIMEOUT_EN
            idle_cnt  <= '0;
`endif
          end else begin
            if (dig_ok) begin
              ps_num    <= dig;
              num_valid <= 1'b1;
              digit_cnt <= digit_cnt + 3'd1;
`ifdef KEY_TIMEOUT_EN
              idle_cnt  <= '0;
`endif
            end
            if (end_ev) begin
              state        <= DONE;
              entry_active <= 1'b0;
              ps_end       <= 1'b1;
            end
`ifdef KEY_TIMEOUT_EN
            else if (!dig_ok && tick_en) begin
              if (idle_cnt == TW'(TIMEOUT_TICKS - 1)) begin
                state        <= IDLE;
                entry_active <= 1'b0;
                timeout      <= 1'b1;
                digit_cnt    <= 3'd0;
                idle_cnt     <= '0;
              end else begin
                idle_cnt <= idle_cnt + 1'b1;
              end
            end
`endif
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state        <= IDLE;
          entry_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_conditioner.sv
// Self-checking bench for keypad_conditioner: directed and random
// presses with bounce, scored against a session-level event model.
module tb_keypad_conditioner;

  localparam int DB   = 8;
  localparam int MAXD = 4;
  localparam int TO   = 1000;
  localparam int HOLD = DB + 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_en = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_end = 1'b0;
  logic [9:0] key_in = '0;
  logic       ps_start;
  logic       ps_end;
  logic [3:0] ps_num;
  logic       num_valid;
  logic [2:0] digit_cnt;
  logic       entry_active;
  logic       timeout;

  keypad_conditioner #(
    .DEBOUNCE_TICKS(DB),
    .MAX_DIGITS(MAXD),
    .TIMEOUT_TICKS(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick_en(tick_en),
    .btn_start(btn_start),
    .btn_end(btn_end),
    .key_in(key_in),
    .ps_start(ps_start),
    .ps_end(ps_end),
    .ps_num(ps_num),
    .num_valid(num_valid),
    .digit_cnt(digit_cnt),
    .entry_active(entry_active),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // one tick every third clock
  int tph = 0;
  always @(negedge clk) begin
    tick_en = (tph == 0);
    tph = (tph == 2) ? 0 : tph + 1;
  end

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 start, 1 digit, 2 end, 3 timeout
  typedef struct {
    int     kind;
    int     val;
    longint cy;
  } rec_t;

  rec_t obs[$];
  rec_t exq[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (ps_start)  obs.push_back('{0, 0, cyc});
      if (num_valid) obs.push_back('{1, int'(ps_num), cyc});
      if (ps_end)    obs.push_back('{2, 0, cyc});
      if (timeout)   obs.push_back('{3, 0, cyc});
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  // Session model: active flag and accepted-digit count.
  bit m_act = 0;
  int m_cnt = 0;

  function automatic void push_exp(int k, int v);
    rec_t r;
    r.kind = k;
    r.val  = v;
    r.cy   = 0;
    exq.push_back(r);
  endfunction

  function automatic void m_event(bit s, bit e, logic [9:0] k);
    int  d;
    bit  f;
    d = 0;
    f = 0;
    for (int i = 0; i < 10; i++) begin
      if (!f && k[i]) begin
        d = i;
        f = 1;
      end
    end
    if (!m_act) begin
      if (s) begin
        push_exp(0, 0);
        m_act = 1;
        m_cnt = 0;
      end
    end else if (s) begin
      push_exp(0, 0);
      m_cnt = 0;
    end else begin
      if (f && m_cnt < MAXD) begin
        push_exp(1, d);
        m_cnt++;
      end
      if (e) begin
        push_exp(2, 0);
        m_act = 0;
      end
    end
  endfunction

  task automatic ticks(int n);
    repeat (n * 3) @(negedge clk);
  endtask

  task automatic check_q(string tag);
    int n;
    chk({tag, "_events"}, obs.size(), exq.size());
    n = (obs.size() < exq.size()) ? obs.size() : exq.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_kind"}, obs[i].kind, exq[i].kind);
      chk({tag, "_val"}, obs[i].val, exq[i].val);
    end
    chk({tag, "_digit_cnt"}, digit_cnt, m_cnt);
    chk({tag, "_entry_active"}, entry_active, m_act);
    obs.delete();
    exq.delete();
  endtask

  bit last_same;

  task automatic act(string tag, bit s, bit e, logic [9:0] k, bit gl);
    logic [11:0] v;
    if (gl) begin
      v = '0;
      v[$urandom_range(11, 0)] = 1'b1;
      @(negedge clk);
      {key_in, btn_end, btn_start} = v;
      ticks($urandom_range(DB - 3, 1));
      @(negedge clk);
      {key_in, btn_end, btn_start} = '0;
      ticks(HOLD);
    end
    @(negedge clk);
    btn_start = s;
    btn_end   = e;
    key_in    = k;
    ticks(HOLD);
    if (gl) begin
      @(negedge clk);
      btn_start = 1'b0;
      btn_end   = 1'b0;
      key_in    = '0;
      ticks($urandom_range(DB - 3, 1));
      @(negedge clk);
      btn_start = s;
      btn_end   = e;
      key_in    = k;
      ticks(HOLD);
    end
    @(negedge clk);
    btn_start = 1'b0;
    btn_end   = 1'b0;
    key_in    = '0;
    ticks(HOLD);
    m_event(s, e, k);
    last_same = (obs.size() >= 2) &&
                (obs[obs.size()-1].cy == obs[obs.size()-2].cy);
    check_q(tag);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_ps_start"}, ps_start, 0);
    chk({tag, "_ps_end"}, ps_end, 0);
    chk({tag, "_ps_num"}, ps_num, 0);
    chk({tag, "_num_valid"}, num_valid, 0);
    chk({tag, "_digit_cnt"}, digit_cnt, 0);
    chk({tag, "_entry_active"}, entry_active, 0);
    chk({tag, "_timeout"}, timeout, 0);
  endtask

  initial begin
    logic [9:0] k;
    int r;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    ticks(2);

    act("start", 1, 0, '0, 0);
    act("dig3", 0, 0, 10'd1 << 3, 1);
    act("dig7", 0, 0, 10'd1 << 7, 1);
    act("end1", 0, 1, '0, 0);

    act("start2", 1, 0, '0, 0);
    for (int d = 1; d <= 6; d++) act("seq", 0, 0, 10'd1 << d, 0);
    act("end2", 0, 1, '0, 0);

    act("start3", 1, 0, '0, 0);
    act("multi", 0, 0, (10'd1 << 5) | (10'd1 << 2), 0);
    act("dig_end", 0, 1, 10'd1 << 8, 0);
    chk("dig_end_same_cycle", last_same, 1);

    act("start_end", 1, 1, '0, 0);
    act("restart", 1, 0, 10'd1 << 4, 0);

    for (int d = 1; d <= 3; d++) act("pre_rst", 0, 0, 10'd1 << d, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("mid_rst");
    obs.delete();
    m_act = 0;
    m_cnt = 0;
    act("post_rst", 0, 0, 10'd1 << 5, 0);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(9, 0);
      k = '0;
      if (r <= 1) act("rnd", 1, 0, '0, $urandom_range(1, 0) == 1);
      else if (r == 2) act("rnd", 0, 1, '0, 0);
      else if (r == 3) act("rnd", 1, 1, '0, 0);
      else if (r <= 8) begin
        k[$urandom_range(9, 0)] = 1'b1;
        act("rnd", 0, 0, k, $urandom_range(1, 0) == 1);
      end else begin
        k = 10'($urandom_range(1023, 1));
        act("rnd", 0, $urandom_range(1, 0) == 1, k, 0);
      end
    end

    act("to_start", 1, 0, '0, 0);
    ticks(TO + 10);
`ifdef KEY_TIMEOUT_EN
    push_exp(3, 0);
    m_act = 0;
    m_cnt = 0;
`endif
    check_q("timeout");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
